io_reg_bank: RTL

- Parametrised successor to the fixed 8-in/18-out IO register cell, sitting between fabric logic and the IO pads.
- Input path: a synchroniser chain with capture enable, one-cycle rising-edge pulses and sticky event flags with write-1-to-clear.
- Output path: registered drivers with load enable. Each channel is either level mode or pulse mode; pulse mode is a one-shot of programmable length.

---
 rtl/io_reg_bank.sv | 119 +++++++++++
 1 files changed

// File: rtl/io_reg_bank.sv
// Pad-side IO register bank: synchronised, gated input capture with edge pulses and sticky
// flags, plus registered output drivers that run in either level or one-shot pulse mode.
module io_reg_bank #(
  parameter int unsigned NUM_IN      = 8,
  parameter int unsigned NUM_OUT     = 18,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_W     = 4
) (
  input  logic               IQC,
  input  logic               QRT,
  input  logic [NUM_IN-1:0]  pad_in,
  input  logic               IQE,
  output logic [NUM_IN-1:0]  IQZ,
  output logic [NUM_IN-1:0]  IQR,
  output logic [NUM_IN-1:0]  evt_flag,
  input  logic [NUM_IN-1:0]  evt_clr,
  input  logic [NUM_OUT-1:0] OQI,
  input  logic               OQE,
  input  logic [NUM_OUT-1:0] pulse_mode,
  input  logic [PULSE_W-1:0] pulse_len,
  output logic [NUM_OUT-1:0] OQZ,
  output logic [NUM_OUT-1:0] busy
);

  // ---------------------------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync_q;
  logic [NUM_IN-1:0] iqz_q, iqz_d;
  logic [NUM_IN-1:0] hist_q;
  logic [NUM_IN-1:0] iqr_q;
  logic [NUM_IN-1:0] flag_q, flag_d;
  logic [NUM_IN-1:0] rise;

  always_comb begin
    iqz_d = IQE ? sync_q[SYNC_STAGES-1] : iqz_q;
    rise  = iqz_q & ~hist_q;
    // Set dominates a clear both on the edge the pulse starts and during the pulse cycle.
    flag_d = (flag_q & ~evt_clr) | rise | iqr_q;
  end

  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      sync_q <= '0;
      iqz_q  <= '0;
      hist_q <= '0;
      iqr_q  <= '0;
      flag_q <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      iqz_q  <= iqz_d;
      hist_q <= iqz_q;
      iqr_q  <= rise;
      flag_q <= flag_d;
    end
  end

  assign IQZ      = iqz_q;
  assign IQR      = iqr_q;
  assign evt_flag = flag_q;

  // ---------------------------------------------------------------------------------------------
  // Output path
  // ---------------------------------------------------------------------------------------------
  logic [NUM_OUT-1:0][PULSE_W-1:0] cnt_q, cnt_d;
  logic [NUM_OUT-1:0] oqz_q, oqz_d;
  logic [NUM_OUT-1:0] mode_q, mode_d;
  logic [NUM_OUT-1:0] busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    oqz_d  = oqz_q;
    mode_d = mode_q;
    busy_d = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (OQE) begin
        mode_d[i] = pulse_mode[i];
        if (!pulse_mode[i]) begin
          cnt_d[i] = '0;
          oqz_d[i] = OQI[i];
        end else if (OQI[i] && (pulse_len != '0)) begin
          cnt_d[i] = pulse_len;
          oqz_d[i] = 1'b1;
        end else begin
          cnt_d[i] = '0;
          oqz_d[i] = 1'b0;
        end
      end else if (mode_q[i]) begin
        // Saturating countdown; the drive follows the counter so high time equals the length.
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - PULSE_W'(1);
        end
        oqz_d[i] = (cnt_d[i] != '0);
      end
      busy_d[i] = |cnt_d[i];
    end
  end

  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      cnt_q  <= '0;
      oqz_q  <= '0;
      mode_q <= '0;
      busy_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      oqz_q  <= oqz_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
    end
  end

  assign OQZ  = oqz_q;
  assign busy = busy_q;

endmodule
